stopwatch_ctrl: RTL and testbench

- Sits directly downstream of the button debouncers.
- Consumes their single-clock press pulses (run/stop, clear) and drives a 3-state control FSM (STOP/RUN/CLEAR).
- The FSM gates a prescaled 100 Hz tick into a cascaded centisecond/second/minute/hour time counter.
- Registered time fields feed the display/FND formatting stage.

---
 rtl/stopwatch_ctrl_if.sv | 47 ++++
 rtl/stopwatch_ctrl.sv | 139 +++++++++++++
 tb/tb_stopwatch_ctrl.sv | 286 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/stopwatch_ctrl_if.sv
// stopwatch_ctrl_if
//   Bundles the button pulses going into the stopwatch controller and the
//   registered state/time fields coming out of it.
//   Signals:
//     i_btn_run   - debounced one-clock pulse, toggles run/stop
//     i_btn_clear - debounced one-clock pulse, requests clear
//     o_state     - FSM state: 0=STOP, 1=RUN, 2=CLEAR
//     o_run       - high while in RUN
//     o_msec      - centiseconds
//     o_sec       - seconds
//     o_min       - minutes
//     o_hour      - hours
//   Modports:
//     master - drives the buttons and observes the outputs (debouncer/bench side)
//     slave  - the controller itself
interface stopwatch_ctrl_if;
  logic       i_btn_run;
  logic       i_btn_clear;
  logic [1:0] o_state;
  logic       o_run;
  logic [6:0] o_msec;
  logic [5:0] o_sec;
  logic [5:0] o_min;
  logic [4:0] o_hour;

  modport master (
    output i_btn_run,
    output i_btn_clear,
    input  o_state,
    input  o_run,
    input  o_msec,
    input  o_sec,
    input  o_min,
    input  o_hour
  );

  modport slave (
    input  i_btn_run,
    input  i_btn_clear,
    output o_state,
    output o_run,
    output o_msec,
    output o_sec,
    output o_min,
    output o_hour
  );
endinterface

// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl
//   Stopwatch control block. Takes debounced run/stop and clear pulses,
//   steps a STOP/RUN/CLEAR state machine, and while running divides the
//   system clock down to a centisecond tick that advances a cascaded
//   centisecond/second/minute/hour counter. All outputs are registers.
//   Ports:
//     clk   - system clock
//     reset - asynchronous, active-high reset
//     bus   - stopwatch_ctrl_if.slave: button pulses in, state and time fields out
//   Parameters:
//     TICK_DIV - clk cycles per centisecond tick
//     MSEC_MAX, SEC_MAX, MIN_MAX, HOUR_MAX - terminal value of each time field
module stopwatch_ctrl #(
  parameter int TICK_DIV = 1_000_000,
  parameter int MSEC_MAX = 99,
  parameter int SEC_MAX  = 59,
  parameter int MIN_MAX  = 59,
  parameter int HOUR_MAX = 23
) (
  input  logic clk,
  input  logic reset,
  stopwatch_ctrl_if.slave bus
);

  // A divide-by-one still needs a one-bit register to keep the vector legal.
  localparam int DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  typedef enum logic [1:0] {
    ST_STOP  = 2'd0,
    ST_RUN   = 2'd1,
    ST_CLEAR = 2'd2
  } state_t;

  state_t           state;
  logic             run_q;
  logic [DIV_W-1:0] div;
  logic             tick;
  logic             zero_fields;
  logic [6:0]       msec_q;
  logic [5:0]       sec_q;
  logic [5:0]       min_q;
  logic [4:0]       hour_q;

  // The tick fires on the last divider count of a RUN cycle only, so pausing
  // freezes the sub-tick phase along with the divider.
  assign tick = (state == ST_RUN) && (div == DIV_W'(TICK_DIV - 1));

  // Fields are zeroed on the edge that enters CLEAR as well as the one that
  // leaves it, so the display already shows zero while o_state reads CLEAR.
  assign zero_fields = (state == ST_CLEAR) ||
                       ((state == ST_STOP) && bus.i_btn_clear);

  // Control FSM. o_run is registered alongside the state so it tracks the
  // state register exactly without a decode after the flop.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_STOP;
      run_q <= 1'b0;
    end else begin
      case (state)
        ST_STOP: begin
          if (bus.i_btn_clear) begin
            state <= ST_CLEAR;
            run_q <= 1'b0;
          end else if (bus.i_btn_run) begin
            state <= ST_RUN;
            run_q <= 1'b1;
          end
        end
        ST_RUN: begin
          if (bus.i_btn_run) begin
            state <= ST_STOP;
            run_q <= 1'b0;
          end
        end
        ST_CLEAR: begin
          state <= ST_STOP;
          run_q <= 1'b0;
        end
        default: begin
          state <= ST_STOP;
          run_q <= 1'b0;
        end
      endcase
    end
  end

  // Prescaler and time cascade. A stop pulse that lands on a tick cycle still
  // sees RUN in the state register, so that final increment is kept.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div    <= '0;
      msec_q <= '0;
      sec_q  <= '0;
      min_q  <= '0;
      hour_q <= '0;
    end else if (zero_fields) begin
      div    <= '0;
      msec_q <= '0;
      sec_q  <= '0;
      min_q  <= '0;
      hour_q <= '0;
    end else if (state == ST_RUN) begin
      if (tick) begin
        div <= '0;
        if (msec_q == 7'(MSEC_MAX)) begin
          msec_q <= '0;
          if (sec_q == 6'(SEC_MAX)) begin
            sec_q <= '0;
            if (min_q == 6'(MIN_MAX)) begin
              min_q <= '0;
              if (hour_q == 5'(HOUR_MAX)) begin
                hour_q <= '0;
              end else begin
                hour_q <= hour_q + 5'd1;
              end
            end else begin
              min_q <= min_q + 6'd1;
            end
          end else begin
            sec_q <= sec_q + 6'd1;
          end
        end else begin
          msec_q <= msec_q + 7'd1;
        end
      end else begin
        div <= div + DIV_W'(1);
      end
    end
  end

  assign bus.o_state = state;
  assign bus.o_run   = run_q;
  assign bus.o_msec  = msec_q;
  assign bus.o_sec   = sec_q;
  assign bus.o_min   = min_q;
  assign bus.o_hour  = hour_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// tb_stopwatch_ctrl
//   Self-checking bench for stopwatch_ctrl. A fixed vector table walks the FSM
//   and prescaler, hand-written sequences cover pause/resume phase, cascade
//   carries, full wrap, clear priority and asynchronous reset, and a random
//   phase is compared against a reference model that tracks elapsed time as
//   a single centisecond total.
module tb_stopwatch_ctrl;

  // Small upper terminals keep a full day wrap within a short run.
  localparam int TICK_DIV  = 4;
  localparam int MSEC_MAX  = 99;
  localparam int SEC_MAX   = 7;
  localparam int MIN_MAX   = 2;
  localparam int HOUR_MAX  = 2;
  localparam int DAY_TICKS = (MSEC_MAX + 1) * (SEC_MAX + 1) * (MIN_MAX + 1) * (HOUR_MAX + 1);

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  stopwatch_ctrl_if bus ();

  stopwatch_ctrl #(
    .TICK_DIV(TICK_DIV),
    .MSEC_MAX(MSEC_MAX),
    .SEC_MAX (SEC_MAX),
    .MIN_MAX (MIN_MAX),
    .HOUR_MAX(HOUR_MAX)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: mode 0=stopped, 1=running, 2=clearing; elapsed time is
  // one centisecond total, sub-tick progress is a count of running edges.
  int m_mode;
  int m_phase;
  int m_total;

  typedef struct {
    logic run;
    logic clr;
    int   exp_state;
    int   exp_run;
    int   exp_msec;
  } vec_t;

  vec_t vecs [23];

  task automatic check_val(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  task automatic model_reset();
    m_mode  = 0;
    m_phase = 0;
    m_total = 0;
  endtask

  task automatic model_edge(input logic r, input logic c);
    case (m_mode)
      0: begin
        if (c) begin
          m_mode  = 2;
          m_phase = 0;
          m_total = 0;
        end else if (r) begin
          m_mode = 1;
        end
      end
      1: begin
        m_phase = m_phase + 1;
        if (m_phase == TICK_DIV) begin
          m_phase = 0;
          m_total = (m_total + 1) % DAY_TICKS;
        end
        if (r) m_mode = 0;
      end
      default: begin
        m_mode  = 0;
        m_phase = 0;
        m_total = 0;
      end
    endcase
  endtask

  task automatic check_output();
    int cs;
    cs = m_total;
    check_val("model_state", int'(bus.o_state), m_mode);
    check_val("model_run",   int'(bus.o_run), (m_mode == 1) ? 1 : 0);
    check_val("model_msec",  int'(bus.o_msec), cs % (MSEC_MAX + 1));
    cs = cs / (MSEC_MAX + 1);
    check_val("model_sec",   int'(bus.o_sec), cs % (SEC_MAX + 1));
    cs = cs / (SEC_MAX + 1);
    check_val("model_min",   int'(bus.o_min), cs % (MIN_MAX + 1));
    cs = cs / (MIN_MAX + 1);
    check_val("model_hour",  int'(bus.o_hour), cs);
  endtask

  // Drives one cycle of inputs, advances the model on the edge and returns
  // 1 ns after it with the buttons released.
  task automatic apply_stimulus(input logic r, input logic c);
    bus.i_btn_run   = r;
    bus.i_btn_clear = c;
    @(posedge clk);
    model_edge(r, c);
    #1;
    bus.i_btn_run   = 1'b0;
    bus.i_btn_clear = 1'b0;
  endtask

  task automatic run_idle(input int n);
    for (int i = 0; i < n; i++) apply_stimulus(1'b0, 1'b0);
  endtask

  task automatic do_reset();
    bus.i_btn_run   = 1'b0;
    bus.i_btn_clear = 1'b0;
    reset = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic check_fields(input string tag, input int ms, input int s, input int mi, input int h);
    check_val({tag, "_msec"}, int'(bus.o_msec), ms);
    check_val({tag, "_sec"},  int'(bus.o_sec),  s);
    check_val({tag, "_min"},  int'(bus.o_min),  mi);
    check_val({tag, "_hour"}, int'(bus.o_hour), h);
  endtask

  initial begin
    vecs[0]  = '{1'b0, 1'b0, 0, 0, 0};
    vecs[1]  = '{1'b1, 1'b1, 2, 0, 0};
    vecs[2]  = '{1'b1, 1'b0, 0, 0, 0};
    vecs[3]  = '{1'b1, 1'b0, 1, 1, 0};
    vecs[4]  = '{1'b0, 1'b1, 1, 1, 0};
    vecs[5]  = '{1'b0, 1'b0, 1, 1, 0};
    vecs[6]  = '{1'b0, 1'b0, 1, 1, 0};
    vecs[7]  = '{1'b0, 1'b0, 1, 1, 1};
    vecs[8]  = '{1'b1, 1'b0, 0, 0, 1};
    vecs[9]  = '{1'b0, 1'b0, 0, 0, 1};
    vecs[10] = '{1'b1, 1'b0, 1, 1, 1};
    vecs[11] = '{1'b0, 1'b0, 1, 1, 1};
    vecs[12] = '{1'b0, 1'b0, 1, 1, 1};
    vecs[13] = '{1'b0, 1'b0, 1, 1, 2};
    vecs[14] = '{1'b0, 1'b1, 1, 1, 2};
    vecs[15] = '{1'b1, 1'b0, 0, 0, 2};
    vecs[16] = '{1'b0, 1'b1, 2, 0, 0};
    vecs[17] = '{1'b0, 1'b0, 0, 0, 0};
    vecs[18] = '{1'b1, 1'b0, 1, 1, 0};
    vecs[19] = '{1'b0, 1'b0, 1, 1, 0};
    vecs[20] = '{1'b0, 1'b0, 1, 1, 0};
    vecs[21] = '{1'b0, 1'b0, 1, 1, 0};
    vecs[22] = '{1'b0, 1'b0, 1, 1, 1};

    // Reset then idle: everything stays at zero.
    do_reset();
    check_val("reset_state", int'(bus.o_state), 0);
    check_val("reset_run",   int'(bus.o_run), 0);
    check_fields("reset", 0, 0, 0, 0);
    run_idle(20);
    check_val("idle_state", int'(bus.o_state), 0);
    check_val("idle_run",   int'(bus.o_run), 0);
    check_fields("idle", 0, 0, 0, 0);

    // Vector table from a fresh reset.
    do_reset();
    for (int i = 0; i < 23; i++) begin
      apply_stimulus(vecs[i].run, vecs[i].clr);
      check_val($sformatf("vec%0d_state", i), int'(bus.o_state), vecs[i].exp_state);
      check_val($sformatf("vec%0d_run", i),   int'(bus.o_run),   vecs[i].exp_run);
      check_val($sformatf("vec%0d_msec", i),  int'(bus.o_msec),  vecs[i].exp_msec);
      check_output();
    end

    // Basic run/stop: 40 running edges give 10 centiseconds, then hold.
    do_reset();
    apply_stimulus(1'b1, 1'b0);
    run_idle(40);
    check_val("run40_state", int'(bus.o_state), 1);
    check_val("run40_msec",  int'(bus.o_msec), 10);
    check_val("run40_sec",   int'(bus.o_sec), 0);
    apply_stimulus(1'b1, 1'b0);
    check_val("stop_state", int'(bus.o_state), 0);
    run_idle(20);
    check_val("hold_msec", int'(bus.o_msec), 10);
    check_val("hold_run",  int'(bus.o_run), 0);

    // Pause/resume keeps the sub-tick phase: six running edges leave the
    // divider two counts in, so two more running edges finish the tick.
    do_reset();
    apply_stimulus(1'b1, 1'b0);
    run_idle(5);
    apply_stimulus(1'b1, 1'b0);
    check_val("pause_msec", int'(bus.o_msec), 1);
    run_idle(10);
    apply_stimulus(1'b1, 1'b0);
    check_val("resume_msec0", int'(bus.o_msec), 1);
    apply_stimulus(1'b0, 1'b0);
    check_val("resume_msec1", int'(bus.o_msec), 1);
    apply_stimulus(1'b0, 1'b0);
    check_val("resume_msec2", int'(bus.o_msec), 2);
    check_output();

    // Cascade carries and full wrap on a single edge.
    do_reset();
    apply_stimulus(1'b1, 1'b0);
    run_idle(99 * TICK_DIV);
    check_fields("pre_carry", 99, 0, 0, 0);
    run_idle(TICK_DIV);
    check_fields("carry", 0, 1, 0, 0);
    run_idle((DAY_TICKS - 1 - 100) * TICK_DIV);
    check_fields("pre_wrap", MSEC_MAX, SEC_MAX, MIN_MAX, HOUR_MAX);
    check_output();
    run_idle(TICK_DIV - 1);
    check_fields("wrap_edge_minus1", MSEC_MAX, SEC_MAX, MIN_MAX, HOUR_MAX);
    run_idle(1);
    check_fields("wrap", 0, 0, 0, 0);
    check_val("wrap_state", int'(bus.o_state), 1);

    // Clear wins over a simultaneous run pulse in STOP.
    do_reset();
    apply_stimulus(1'b1, 1'b0);
    run_idle(37 * TICK_DIV);
    apply_stimulus(1'b1, 1'b0);
    check_val("pre_clear_state", int'(bus.o_state), 0);
    check_val("pre_clear_msec",  int'(bus.o_msec), 37);
    apply_stimulus(1'b1, 1'b1);
    check_val("clear_state", int'(bus.o_state), 2);
    check_val("clear_run",   int'(bus.o_run), 0);
    check_fields("clear", 0, 0, 0, 0);
    apply_stimulus(1'b0, 1'b0);
    check_val("post_clear_state", int'(bus.o_state), 0);
    check_val("post_clear_run",   int'(bus.o_run), 0);
    check_fields("post_clear", 0, 0, 0, 0);

    // Clear is ignored while running; reset mid-count clears asynchronously.
    do_reset();
    apply_stimulus(1'b1, 1'b0);
    run_idle(10);
    apply_stimulus(1'b0, 1'b1);
    check_val("run_clear_state", int'(bus.o_state), 1);
    run_idle(500 * TICK_DIV - 11);
    check_fields("sec5", 0, 5, 0, 0);
    #2;
    reset = 1'b1;
    model_reset();
    #1;
    check_val("async_state", int'(bus.o_state), 0);
    check_val("async_run",   int'(bus.o_run), 0);
    check_fields("async", 0, 0, 0, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    run_idle(8);
    check_val("post_reset_state", int'(bus.o_state), 0);
    check_fields("post_reset", 0, 0, 0, 0);

    // Random pulses against the reference model.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      logic r;
      logic c;
      r = ($urandom_range(0, 15) == 0);
      c = ($urandom_range(0, 19) == 0);
      apply_stimulus(r, c);
      check_output();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
